// File: rtl/ov7670_capture_if.sv
// OV7670 DVP sensor bus plus frame-cache write port, bundled for ov7670_capture.
// master = sensor/cache side (drives camera pins and cache ready), slave = capture block.
interface ov7670_capture_if;
   logic        cam_pclk;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        cache_wr_en;
   logic        cache_wreq;
   logic [15:0] cache_data;
   logic        cache_wclk;
   logic        frame_valid;
   logic        frame_done;
   logic        overflow;

   modport master (
      output cam_pclk, cam_vsync, cam_href, cam_data, cache_wr_en,
      input  cache_wreq, cache_data, cache_wclk, frame_valid, frame_done, overflow
   );

   modport slave (
      input  cam_pclk, cam_vsync, cam_href, cam_data, cache_wr_en,
      output cache_wreq, cache_data, cache_wclk, frame_valid, frame_done, overflow
   );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: oversamples the DVP bus on CLK_40M, pairs bytes into RGB565 pixels and writes an
// X_SIZE x Y_SIZE window per frame into the cache. Define CAPTURE_TEST_PATTERN_EN for a counting pattern.
module ov7670_capture #(
   parameter int X_SIZE      = 240,
   parameter int Y_SIZE      = 320,
   parameter int SKIP_FRAMES = 2
) (
   input  logic            CLK_40M,
   input  logic            RST_N,
   ov7670_capture_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SKIP,
      ST_CAPTURE,
      ST_DONE,
      ST_WAIT
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  pclk_sync, vs_sync, href_sync;
   logic [7:0]  data_s1, data_s2;
   logic        pclk_rise, vs_rise, vs_fall, href_rise, href_fall;
   logic [15:0] skip_cnt, pix_cnt, line_cnt;
   logic        byte_phase;
   logic [7:0]  hi;
   logic        pix_pend;
   logic [15:0] pix_word;
   logic        wreq;
   logic [15:0] wdata;
   logic        ovf;
   logic        frame_start, skip_inc, last_line;

   // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous s2, used for edge detection).
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         pclk_sync <= '0;
         vs_sync   <= '0;
         href_sync <= '0;
         data_s1   <= '0;
         data_s2   <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
         pclk_sync <= {pclk_sync[1:0], bus.cam_pclk};
         vs_sync   <= {vs_sync[1:0], bus.cam_vsync};
         href_sync <= {href_sync[1:0], bus.cam_href};
         data_s1   <= bus.cam_data;
         data_s2   <= data_s1;
      end
   end

   assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
   assign vs_rise   = vs_sync[1] & ~vs_sync[2];
   assign vs_fall   = ~vs_sync[1] & vs_sync[2];
   assign href_rise = href_sync[1] & ~href_sync[2];
   assign href_fall = ~href_sync[1] & href_sync[2];

   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt   = state;
      frame_start = 1'b0;
      skip_inc    = 1'b0;
      last_line   = href_fall && (pix_cnt != 16'd0) && (line_cnt + 16'd1 >= 16'(Y_SIZE));
      case (state)
         ST_IDLE: begin
            if (vs_fall) begin
               if (skip_cnt < 16'(SKIP_FRAMES)) begin
                  state_nxt = ST_SKIP;
                  skip_inc  = 1'b1;
               end else begin
                  state_nxt   = ST_CAPTURE;
                  frame_start = 1'b1;
               end
            end
         end
         ST_SKIP:    if (vs_rise) state_nxt = ST_IDLE;
         ST_CAPTURE: begin
            // A second vs_fall means the closing vs_rise was missed: restart the frame silently.
            if (vs_fall)                     frame_start = 1'b1;
            else if (vs_rise || last_line)   state_nxt   = ST_DONE;
         end
         ST_DONE:    state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (vs_fall) begin
               state_nxt   = ST_CAPTURE;
               frame_start = 1'b1;
            end
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Byte pairing and window counters; a completed in-window pixel is staged in pix_word for one cycle.
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         skip_cnt   <= '0;
         pix_cnt    <= '0;
         line_cnt   <= '0;
         byte_phase <= 1'b0;
         hi         <= '0;
         pix_pend   <= 1'b0;
         pix_word   <= '0;
      end else begin
         pix_pend <= 1'b0;
         if (skip_inc) skip_cnt <= skip_cnt + 16'd1;
         if (frame_start) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            byte_phase <= 1'b0;
         end else if (state == ST_CAPTURE) begin
            if (pclk_rise && href_sync[1]) begin
               if (href_rise || !byte_phase) begin
                  hi         <= data_s2;
                  byte_phase <= 1'b1;
               end else begin
                  byte_phase <= 1'b0;
                  if (pix_cnt < 16'(X_SIZE) && line_cnt < 16'(Y_SIZE)) begin
                     pix_pend <= 1'b1;
                     pix_cnt  <= pix_cnt + 16'd1;
`ifdef CAPTURE_TEST_PATTERN_EN
                     pix_word <= 16'(({16'd0, line_cnt} * 32'(X_SIZE)) + {16'd0, pix_cnt});
`else
                     pix_word <= {hi, data_s2};
`endif
                  end
               end
            end else if (href_rise) begin
               byte_phase <= 1'b0;
            end
            if (href_fall) begin
               if (pix_cnt != 16'd0) line_cnt <= line_cnt + 16'd1;
               pix_cnt <= '0;
            end
         end
      end
   end

   // Write stage: a staged pixel is either strobed out or dropped and flagged.
   always_ff @(posedge CLK_40M or negedge RST_N) begin
      if (!RST_N) begin
         wreq  <= 1'b0;
         wdata <= '0;
         ovf   <= 1'b0;
      end else begin
         wreq <= pix_pend & bus.cache_wr_en;
         if (pix_pend && bus.cache_wr_en) wdata <= pix_word;
         if (frame_start)                      ovf <= 1'b0;
         else if (pix_pend && !bus.cache_wr_en) ovf <= 1'b1;
      end
   end

   assign bus.cache_wreq  = wreq;
   assign bus.cache_data  = wdata;
   assign bus.cache_wclk  = ~CLK_40M;
   assign bus.frame_valid = (state == ST_CAPTURE);
   assign bus.frame_done  = (state == ST_DONE);
   assign bus.overflow    = ovf;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture with a 6x5 window and two skipped frames: a table of frame shapes with
// hand-counted results, random frames against a byte-level frame model, and latency/reset sequences.
module tb_ov7670_capture;

   localparam int X    = 6;
   localparam int Y    = 5;
   localparam int SKIP = 2;

   typedef struct {
      int nlines;
      int nbytes;
      int drop;
      int strobes;
      int done;
      bit ovf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   m_skip = 0;
   logic [15:0] got_q[$];
   int   got_done = 0;
   vec_t vecs[8];

   ov7670_capture_if bus();

   ov7670_capture #(
      .X_SIZE(X),
      .Y_SIZE(Y),
      .SKIP_FRAMES(SKIP)
   ) dut (
      .CLK_40M(clk),
      .RST_N(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.cache_wreq) got_q.push_back(bus.cache_data);
      if (bus.frame_done) got_done++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One byte: data with PCLK low for two cycles, then PCLK high for two cycles.
   task automatic send_byte(input logic [7:0] b, input bit set_en, input bit en);
      bus.cam_pclk = 1'b0;
      bus.cam_data = b;
      repeat (2) @(negedge clk);
      if (set_en) bus.cache_wr_en = en;
      bus.cam_pclk = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic line_start();
      bus.cam_href = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic line_end();
      bus.cam_pclk = 1'b0;
      repeat (2) @(negedge clk);
      bus.cam_href = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_open();
      bus.cam_vsync = 1'b1;
      repeat (4) @(negedge clk);
      bus.cam_vsync = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // Sends one frame of random bytes and predicts the written window from the frame's byte list.
   task automatic run_frame(input int nlines, input int nbytes, input int drop_idx, input bit rand_en,
                            output int n_wr, output int n_done, output bit ovf_seen);
      bit cap, over, exp_ovf, en;
      int lines_done, win_idx, line_pix, exp_done;
      logic [7:0] b, hi;
      logic [15:0] exp_q[$];
      cap = (m_skip >= SKIP);
      if (!cap) m_skip++;
      over = 1'b0; exp_ovf = 1'b0; en = 1'b1;
      lines_done = 0; win_idx = 0; exp_done = 0; hi = '0;
      got_q.delete();
      got_done = 0;
      frame_open();
      check("valid", bus.frame_valid, cap);
      for (int l = 0; l < nlines; l++) begin
         line_start();
         line_pix = 0;
         for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom);
            if (k % 2 == 0) begin
               en = rand_en ? ($urandom_range(0, 3) != 0) : (win_idx != drop_idx);
               hi = b;
               send_byte(b, 1'b1, en);
            end else begin
               send_byte(b, 1'b0, en);
               if (cap && !over && line_pix < X) begin
                  if (en) exp_q.push_back({hi, b});
                  else    exp_ovf = 1'b1;
                  win_idx++;
               end
               line_pix++;
            end
         end
         line_end();
         if (cap && !over && line_pix > 0) begin
            lines_done++;
            if (lines_done == Y) begin
               over = 1'b1;
               exp_done++;
            end
         end
      end
      bus.cam_vsync = 1'b1;
      if (cap && !over) exp_done++;
      repeat (10) @(negedge clk);
      check("strobes", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check("pixel", got_q[i], exp_q[i]);
      check("done", 32'(got_done), 32'(exp_done));
      if (cap) check("overflow", bus.overflow, exp_ovf);
      n_wr     = got_q.size();
      n_done   = got_done;
      ovf_seen = bus.overflow;
   endtask

   initial begin
      int n_wr, n_done, n_pre;
      bit ovf_seen;

      vecs[0] = '{nlines: 4, nbytes: 8,  drop: -1, strobes: 16, done: 1, ovf: 1'b0};
      vecs[1] = '{nlines: 3, nbytes: 16, drop: -1, strobes: 18, done: 1, ovf: 1'b0};
      vecs[2] = '{nlines: 7, nbytes: 14, drop: -1, strobes: 30, done: 1, ovf: 1'b0};
      vecs[3] = '{nlines: 5, nbytes: 4,  drop: -1, strobes: 10, done: 1, ovf: 1'b0};
      vecs[4] = '{nlines: 2, nbytes: 7,  drop: -1, strobes: 6,  done: 1, ovf: 1'b0};
      vecs[5] = '{nlines: 3, nbytes: 8,  drop: 5,  strobes: 11, done: 1, ovf: 1'b1};
      vecs[6] = '{nlines: 2, nbytes: 8,  drop: -1, strobes: 8,  done: 1, ovf: 1'b0};
      vecs[7] = '{nlines: 3, nbytes: 1,  drop: -1, strobes: 0,  done: 1, ovf: 1'b0};

      bus.cam_pclk    = 1'b0;
      bus.cam_vsync   = 1'b0;
      bus.cam_href    = 1'b0;
      bus.cam_data    = '0;
      bus.cache_wr_en = 1'b1;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wreq", bus.cache_wreq, 1'b0);
      check("rst_data", bus.cache_data, 16'h0000);
      check("rst_valid", bus.frame_valid, 1'b0);
      check("rst_done", bus.frame_done, 1'b0);
      check("rst_ovf", bus.overflow, 1'b0);
      check("wclk", bus.cache_wclk, 1'b1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Settling frames after reset produce nothing.
      for (int f = 0; f < SKIP; f++) begin
         run_frame(4, 8, -1, 1'b0, n_wr, n_done, ovf_seen);
         check("skip_strobes", 32'(n_wr), 32'd0);
         check("skip_done", 32'(n_done), 32'd0);
      end

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].nlines, vecs[i].nbytes, vecs[i].drop, 1'b0, n_wr, n_done, ovf_seen);
         check("tbl_strobes", 32'(n_wr), 32'(vecs[i].strobes));
         check("tbl_done", 32'(n_done), 32'(vecs[i].done));
         check("tbl_ovf", ovf_seen, vecs[i].ovf);
      end

      // Latency: strobe appears after the third edge following the first sample of PCLK high.
      got_q.delete();
      got_done = 0;
      bus.cache_wr_en = 1'b1;
      frame_open();
      line_start();
      send_byte(8'hF8, 1'b1, 1'b1);
      bus.cam_pclk = 1'b0;
      bus.cam_data = 8'h1F;
      repeat (2) @(negedge clk);
      bus.cam_pclk = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("lat_early", bus.cache_wreq, 1'b0);
      end
      @(negedge clk);
      check("lat_wreq", bus.cache_wreq, 1'b1);
      check("lat_data", bus.cache_data, 16'hF81F);
      @(negedge clk);
      check("lat_pulse", bus.cache_wreq, 1'b0);
      check("lat_hold", bus.cache_data, 16'hF81F);
      line_end();
      bus.cam_vsync = 1'b1;
      repeat (10) @(negedge clk);
      check("lat_count", 32'(got_q.size()), 32'd1);
      check("lat_done", 32'(got_done), 32'd1);

      for (int f = 0; f < 6; f++)
         run_frame($urandom_range(1, 8), $urandom_range(1, 16), -1, 1'b1, n_wr, n_done, ovf_seen);

      // Reset in the middle of a captured line, released mid-frame.
      got_q.delete();
      got_done = 0;
      bus.cache_wr_en = 1'b1;
      frame_open();
      line_start();
      for (int k = 0; k < 6; k++) send_byte(8'($urandom), k % 2 == 0, 1'b1);
      bus.cam_pclk = 1'b0;
      repeat (4) @(negedge clk);
      n_pre = got_q.size();
      check("mid_pre", 32'(n_pre), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_wreq", bus.cache_wreq, 1'b0);
      check("mid_data", bus.cache_data, 16'h0000);
      check("mid_valid", bus.frame_valid, 1'b0);
      check("mid_ovf", bus.overflow, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(8'($urandom), k % 2 == 0, 1'b1);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) send_byte(8'($urandom), k % 2 == 0, 1'b1);
      check("mid_valid_after", bus.frame_valid, 1'b0);
      line_end();
      line_start();
      for (int k = 0; k < 8; k++) send_byte(8'($urandom), k % 2 == 0, 1'b1);
      line_end();
      bus.cam_vsync = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_after", 32'(got_q.size()), 32'(n_pre));
      check("mid_done", 32'(got_done), 32'd0);

      // Reset re-arms the settling frames.
      m_skip = 0;
      for (int f = 0; f < SKIP + 1; f++)
         run_frame(3, 6, -1, 1'b0, n_wr, n_done, ovf_seen);
      check("rearm_strobes", 32'(n_wr), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
